// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath controller: FSM states, instruction
// encodings, ALU/shift encodings and the datapath word width.
package datapath_pkg;
  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_LOAD_A, S_LOAD_B, S_ALU, S_CMP, S_WRITE_C, S_WRITE_IMM
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;
endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Instruction field extraction, immediate sign-extension and class/legality
// decode of the latched instruction word.
module instr_dec #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_ir,
  output logic [2:0]       o_rn,
  output logic [2:0]       o_rd,
  output logic [2:0]       o_rm,
  output logic [1:0]       o_sh,
  output logic [WIDTH-1:0] o_imm8x,
  output logic [WIDTH-1:0] o_imm5x,
  output datapath_pkg::iclass_t o_cls
);
  import datapath_pkg::*;

  logic [2:0] w_opc;
  logic [1:0] w_op;

  assign w_opc   = i_ir[15:13];
  assign w_op    = i_ir[12:11];
  assign o_rn    = i_ir[10:8];
  assign o_rd    = i_ir[7:5];
  assign o_sh    = i_ir[4:3];
  assign o_rm    = i_ir[2:0];
  assign o_imm8x = {{(WIDTH-8){i_ir[7]}}, i_ir[7:0]};
  assign o_imm5x = {{(WIDTH-5){i_ir[4]}}, i_ir[4:0]};

  // Only six opcode/op pairs are defined; everything else decodes illegal.
  always_comb begin
    o_cls = C_ILL;
    if (w_opc == OPC_MOV) begin
      if (w_op == OP_MOVI)      o_cls = C_MOVI;
      else if (w_op == OP_MOVR) o_cls = C_MOVR;
    end else if (w_opc == OPC_ALU) begin
      unique case (w_op)
        OP_ADD:  o_cls = C_ADD;
        OP_CMP:  o_cls = C_CMP;
        OP_AND:  o_cls = C_AND;
        default: o_cls = C_MVN;
      endcase
    end
  end
endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing the register-file/ALU datapath,
// one instruction per accepted start request.
module datapath_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             vsel,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in,
  output logic [WIDTH-1:0] aselin,
  output logic [WIDTH-1:0] bselin
);
  import datapath_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_ir;

  logic [2:0]       w_rn, w_rd, w_rm;
  logic [1:0]       w_sh;
  logic [WIDTH-1:0] w_imm8x, w_imm5x;
  iclass_t          w_cls;

  instr_dec #(.WIDTH(WIDTH)) u_dec (
    .i_ir    (r_ir),
    .o_rn    (w_rn),
    .o_rd    (w_rd),
    .o_rm    (w_rm),
    .o_sh    (w_sh),
    .o_imm8x (w_imm8x),
    .o_imm5x (w_imm5x),
    .o_cls   (w_cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      unique case (r_state)
        S_WAIT: if (s) begin
          r_ir    <= in;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          unique case (w_cls)
            C_MOVI:                r_state <= S_WRITE_IMM;
            C_MOVR, C_MVN:         r_state <= S_LOAD_B;
            C_ADD, C_CMP, C_AND:   r_state <= S_LOAD_A;
            default:               r_state <= S_WAIT;
          endcase
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= (w_cls == C_CMP) ? S_CMP : S_ALU;
        S_ALU:    r_state <= S_WRITE_C;
        default:  r_state <= S_WAIT;
      endcase
    end
  end

  // Outputs decode from r_state/r_ir only, so s/in never reach them.
  always_comb begin
    w        = (r_state == S_WAIT);
    err      = (r_state == S_DECODE) && (w_cls == C_ILL);
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    vsel     = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    unique case (r_state)
      S_LOAD_A: begin readnum = w_rn; loada = 1'b1; end
      S_LOAD_B: begin readnum = w_rm; loadb = 1'b1; end
      S_ALU: begin
        shift = w_sh;
        loadc = 1'b1;
        // Single-operand forms zero the A side and pass B through the ALU.
        asel  = (w_cls == C_MOVR) || (w_cls == C_MVN);
        if (w_cls == C_AND)      ALUop = ALU_AND;
        else if (w_cls == C_MVN) ALUop = ALU_MVN;
      end
      S_CMP: begin
        shift = w_sh;
        ALUop = ALU_SUB;
        loads = 1'b1;
      end
      S_WRITE_C:   begin writenum = w_rd; write = 1'b1; end
      S_WRITE_IMM: begin writenum = w_rn; write = 1'b1; vsel = 1'b1; end
      default: ;
    endcase
  end

  assign datapath_in = w_imm8x;
  assign bselin      = w_imm5x;
  assign aselin      = '0;
endmodule
